// File: rtl/life_pkg.sv
// Shared types and constants for the Life board step sequencer.
package life_pkg;

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Flat board bit index of row r, column c (8*r + c).
  function automatic logic [5:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
    return {r, c};
  endfunction

endpackage

// File: rtl/life_row_next.sv
// Next-generation value of one board row from its two vertical neighbours.
module life_row_next
  import life_pkg::*;
(
  input  logic [COLS-1:0] prev_row,
  input  logic [COLS-1:0] cur_row,
  input  logic [COLS-1:0] next_row,
  input  logic            wrap,
  output logic [COLS-1:0] row_out
);

  logic [2:0] cc;
  logic [2:0] lc;
  logic [2:0] rc;
  logic       le;
  logic       re;
  logic [3:0] n;

  // Missing rows arrive as zero; missing columns are masked by le/re.
  always_comb begin
    row_out = '0;
    cc      = '0;
    lc      = '0;
    rc      = '0;
    le      = 1'b0;
    re      = 1'b0;
    n       = '0;
    for (int c = 0; c < int'(COLS); c++) begin
      cc = 3'(c);
      lc = cc - 3'd1;
      rc = cc + 3'd1;
      le = wrap || (cc != 3'd0);
      re = wrap || (cc != 3'(COLS - 1));
      n  = 4'(prev_row[lc] & le) + 4'(prev_row[cc]) + 4'(prev_row[rc] & re)
         + 4'(cur_row[lc] & le)                     + 4'(cur_row[rc] & re)
         + 4'(next_row[lc] & le) + 4'(next_row[cc]) + 4'(next_row[rc] & re);
      row_out[cc] = (n == 4'd3) || (cur_row[cc] && (n == 4'd2));
    end
  end

endmodule

// File: rtl/life_step_ctrl.sv
// Arbitrates the board row-write port between user writes and Life generation steps.
module life_step_ctrl
  import life_pkg::*;
#(
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned GEN_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          cells,
  input  logic                 user_valid,
  input  logic [2:0]           user_row,
  input  logic [7:0]           user_val,
  output logic                 user_ready,
  input  logic                 step,
  input  logic                 run,
  input  logic [PERIOD_W-1:0]  period,
  input  logic                 wrap,
  output logic                 load_r,
  output logic [2:0]           r_select,
  output logic [7:0]           r_val,
  output logic                 busy,
  output logic                 gen_done,
  output logic [GEN_W-1:0]     gen_count
);

  state_t               state;
  logic [ROWS*COLS-1:0] snap;
  logic                 wrap_q;
  logic                 pending;
  logic [PERIOD_W-1:0]  per_cnt;

  logic [ROWS*COLS-1:0] board_c;
  logic                 wrap_c;
  logic [2:0]           idx_c;
  logic [2:0]           prev_idx_c;
  logic [2:0]           next_idx_c;
  logic [COLS-1:0]      prev_row_c;
  logic [COLS-1:0]      cur_row_c;
  logic [COLS-1:0]      next_row_c;
  logic [COLS-1:0]      row_next_c;
  logic [PERIOD_W-1:0]  per_last_c;
  logic                 auto_c;
  logic                 trigger_c;
  logic                 user_acc_c;
  logic                 step_acc_c;

  // Row 0 is computed straight from cells on acceptance; later rows from the snapshot.
  always_comb begin
    board_c = snap;
    wrap_c  = wrap_q;
    idx_c   = r_select + 3'd1;
    if (state == IDLE) begin
      board_c = cells;
      wrap_c  = wrap;
      idx_c   = 3'd0;
    end
    prev_idx_c = idx_c - 3'd1;
    next_idx_c = idx_c + 3'd1;
    cur_row_c  = board_c[cell_idx(idx_c, 3'd0) +: COLS];
    prev_row_c = '0;
    next_row_c = '0;
    if (wrap_c || (idx_c != 3'd0))
      prev_row_c = board_c[cell_idx(prev_idx_c, 3'd0) +: COLS];
    if (wrap_c || (idx_c != 3'(ROWS - 1)))
      next_row_c = board_c[cell_idx(next_idx_c, 3'd0) +: COLS];
  end

  life_row_next u_row_next (
    .prev_row (prev_row_c),
    .cur_row  (cur_row_c),
    .next_row (next_row_c),
    .wrap     (wrap_c),
    .row_out  (row_next_c)
  );

  // A step waits while a user write is in flight so the snapshot sees it.
  always_comb begin
    per_last_c = (period == '0) ? '0 : period - PERIOD_W'(1);
    auto_c     = run && (per_cnt >= per_last_c);
    trigger_c  = step || pending || auto_c;
    user_acc_c = (state == IDLE) && user_valid && user_ready;
    step_acc_c = (state == IDLE) && trigger_c && !user_acc_c && !load_r;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      load_r     <= 1'b0;
      r_select   <= '0;
      r_val      <= '0;
      user_ready <= 1'b0;
      busy       <= 1'b0;
      gen_done   <= 1'b0;
      gen_count  <= '0;
      pending    <= 1'b0;
      per_cnt    <= '0;
      snap       <= '0;
      wrap_q     <= 1'b0;
    end else begin
      load_r   <= 1'b0;
      gen_done <= 1'b0;
      per_cnt  <= '0;
      case (state)
        IDLE: begin
          user_ready <= 1'b1;
          if (run && !step_acc_c)
            per_cnt <= per_cnt + PERIOD_W'(1);
          if (step_acc_c) begin
            snap       <= cells;
            wrap_q     <= wrap;
            pending    <= 1'b0;
            state      <= WRITE;
            user_ready <= 1'b0;
            busy       <= 1'b1;
            load_r     <= 1'b1;
            r_select   <= 3'd0;
            r_val      <= row_next_c;
          end else begin
            if (trigger_c)
              pending <= 1'b1;
            if (user_acc_c) begin
              load_r   <= 1'b1;
              r_select <= user_row;
              r_val    <= user_val;
            end
          end
        end
        WRITE: begin
          if (step)
            pending <= 1'b1;
          if (r_select == 3'(ROWS - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            gen_done  <= 1'b1;
            gen_count <= gen_count + GEN_W'(1);
          end else begin
            load_r   <= 1'b1;
            r_select <= r_select + 3'd1;
            r_val    <= row_next_c;
          end
        end
        DONE: begin
          if (step)
            pending <= 1'b1;
          state      <= IDLE;
          user_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_step_ctrl.sv
// Self-checking bench for life_step_ctrl with a behavioural board register and Life model.
module tb_life_step_ctrl;

  logic        clk;
  logic        reset;
  logic [63:0] cells;
  logic        user_valid;
  logic [2:0]  user_row;
  logic [7:0]  user_val;
  logic        user_ready;
  logic        step;
  logic        run;
  logic [23:0] period;
  logic        wrap;
  logic        load_r;
  logic [2:0]  r_select;
  logic [7:0]  r_val;
  logic        busy;
  logic        gen_done;
  logic [15:0] gen_count;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   exp_gen  = 0;
  logic clr;

  life_step_ctrl #(.PERIOD_W(24), .GEN_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .cells      (cells),
    .user_valid (user_valid),
    .user_row   (user_row),
    .user_val   (user_val),
    .user_ready (user_ready),
    .step       (step),
    .run        (run),
    .period     (period),
    .wrap       (wrap),
    .load_r     (load_r),
    .r_select   (r_select),
    .r_val      (r_val),
    .busy       (busy),
    .gen_done   (gen_done),
    .gen_count  (gen_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The board register that the controller writes into.
  always @(posedge clk) begin
    if (clr)
      cells <= '0;
    else if (load_r)
      cells[r_select*8 +: 8] <= r_val;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Conway rule over the whole board, straight from neighbour counting.
  function automatic logic [63:0] life(input logic [63:0] b, input logic w);
    logic [63:0] nb;
    nb = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr;
            int cc;
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (w) begin
              rr = (rr + 8) % 8;
              cc = (cc + 8) % 8;
            end else if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
              continue;
            end
            n += int'(b[rr*8 + cc]);
          end
        end
        nb[r*8 + c] = (n == 3) || (b[r*8 + c] && n == 2);
      end
    end
    return nb;
  endfunction

  task automatic load_board(input logic [63:0] b);
    for (int j = 0; j <= 8; j++) begin
      if (j < 8) begin
        checks++;
        if (user_ready !== 1'b1) begin
          failures++;
          $display("FAIL load_ready j=%0d: got user_ready=%b want 1", j, user_ready);
        end
        user_valid = 1'b1;
        user_row   = 3'(j);
        user_val   = b[j*8 +: 8];
      end else begin
        user_valid = 1'b0;
      end
      if (j > 0) begin
        checks++;
        if ({load_r, r_select, r_val} !== {1'b1, 3'(j-1), b[(j-1)*8 +: 8]}) begin
          failures++;
          $display("FAIL user_write row%0d: got load_r=%b sel=%0d val=%h want 1 %0d %h",
                   j-1, load_r, r_select, r_val, j-1, b[(j-1)*8 +: 8]);
        end
      end
      tick();
    end
    checks++;
    if (cells !== b) begin
      failures++;
      $display("FAIL board_load: got %h want %h", cells, b);
    end
  endtask

  // Called on the first WRITE cycle; ends on the IDLE entry cycle.
  task automatic check_gen(input string name, input logic [63:0] exp);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({load_r, r_select, r_val, busy} !== {1'b1, 3'(k), exp[k*8 +: 8], 1'b1}) begin
        failures++;
        $display("FAIL %s row%0d: got load_r=%b sel=%0d val=%h busy=%b want 1 %0d %h 1",
                 name, k, load_r, r_select, r_val, busy, k, exp[k*8 +: 8]);
      end
      tick();
    end
    exp_gen++;
    checks++;
    if ({load_r, busy, gen_done, gen_count} !== {1'b0, 1'b0, 1'b1, 16'(exp_gen)}) begin
      failures++;
      $display("FAIL %s done: got load_r=%b busy=%b gen_done=%b gen_count=%0d want 0 0 1 %0d",
               name, load_r, busy, gen_done, gen_count, 16'(exp_gen));
    end
    tick();
    checks++;
    if ({gen_done, busy, user_ready} !== 3'b001) begin
      failures++;
      $display("FAIL %s idle: got gen_done=%b busy=%b user_ready=%b want 0 0 1",
               name, gen_done, busy, user_ready);
    end
  endtask

  task automatic do_step(input string name, input logic w, input logic [63:0] exp);
    wrap = w;
    step = 1'b1;
    tick();
    step = 1'b0;
    check_gen(name, exp);
  endtask

  task automatic wait_done(input string name, output int t);
    int n;
    n = 0;
    t = -1;
    while (gen_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (gen_done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: got no gen_done within %0d cycles want pulse", name, n);
    end else begin
      t = cyc;
    end
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({load_r, r_select, r_val, user_ready, busy, gen_done, gen_count} !== 31'd0) begin
      failures++;
      $display("FAIL reset_vals: got load_r=%b sel=%0d val=%h ready=%b busy=%b done=%b cnt=%0d want all 0",
               load_r, r_select, r_val, user_ready, busy, gen_done, gen_count);
    end
    reset = 1'b0;
    clr   = 1'b0;
    tick();
    checks++;
    if ({user_ready, load_r, busy} !== 3'b100) begin
      failures++;
      $display("FAIL reset_release: got ready=%b load_r=%b busy=%b want 1 0 0", user_ready, load_r, busy);
    end
  endtask

  task automatic test_blinker();
    load_board(64'h00000000_1C000000);
    do_step("blinker", 1'b0, 64'h00000008_08080000);
  endtask

  task automatic test_corner();
    load_board(64'h81000000_00000081);
    do_step("corner_wrap", 1'b1, 64'h81000000_00000081);
    do_step("corner_nowrap", 1'b0, 64'h0);
  endtask

  task automatic test_simultaneous();
    wrap       = 1'b0;
    checks++;
    if (user_ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_pre: got user_ready=%b want 1", user_ready);
    end
    user_valid = 1'b1;
    user_row   = 3'd2;
    user_val   = 8'h07;
    step       = 1'b1;
    tick();
    user_valid = 1'b0;
    step       = 1'b0;
    checks++;
    if ({load_r, r_select, r_val, busy} !== {1'b1, 3'd2, 8'h07, 1'b0}) begin
      failures++;
      $display("FAIL simul_user_first: got load_r=%b sel=%0d val=%h busy=%b want 1 2 07 0",
               load_r, r_select, r_val, busy);
    end
    tick();
    checks++;
    if ({load_r, busy} !== 2'b00) begin
      failures++;
      $display("FAIL simul_gap: got load_r=%b busy=%b want 0 0", load_r, busy);
    end
    tick();
    check_gen("simul_step", 64'h00000000_02020200);
  endtask

  task automatic test_pending();
    logic [63:0] exp1;
    int          busy_seen;
    exp1 = 64'h00000000_00070000;
    wrap = 1'b0;
    step = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      step = (k == 2 || k == 5);
      checks++;
      if ({load_r, r_select, r_val, busy} !== {1'b1, 3'(k), exp1[k*8 +: 8], 1'b1}) begin
        failures++;
        $display("FAIL pending_gen1 row%0d: got load_r=%b sel=%0d val=%h busy=%b want 1 %0d %h 1",
                 k, load_r, r_select, r_val, busy, k, exp1[k*8 +: 8]);
      end
      tick();
    end
    step = 1'b1;
    exp_gen++;
    checks++;
    if ({gen_done, gen_count} !== {1'b1, 16'(exp_gen)}) begin
      failures++;
      $display("FAIL pending_done1: got gen_done=%b gen_count=%0d want 1 %0d", gen_done, gen_count, 16'(exp_gen));
    end
    tick();
    step = 1'b0;
    checks++;
    if ({busy, gen_done, load_r} !== 3'b000) begin
      failures++;
      $display("FAIL pending_idle: got busy=%b done=%b load_r=%b want 0 0 0", busy, gen_done, load_r);
    end
    tick();
    check_gen("pending_gen2", 64'h00000000_02020200);
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy === 1'b1) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin
      failures++;
      $display("FAIL pending_one_deep: got %0d busy cycles want 0", busy_seen);
    end
  endtask

  task automatic test_stall();
    int n;
    wrap = 1'b0;
    step = 1'b1;
    tick();
    step       = 1'b0;
    user_valid = 1'b1;
    user_row   = 3'd5;
    user_val   = 8'hA5;
    n = 0;
    while (user_ready !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n != 9) begin
      failures++;
      $display("FAIL stall_cycles: got %0d stalled cycles want 9", n);
    end
    tick();
    user_valid = 1'b0;
    exp_gen++;
    checks++;
    if ({load_r, r_select, r_val, gen_count} !== {1'b1, 3'd5, 8'hA5, 16'(exp_gen)}) begin
      failures++;
      $display("FAIL stall_write: got load_r=%b sel=%0d val=%h cnt=%0d want 1 5 a5 %0d",
               load_r, r_select, r_val, gen_count, 16'(exp_gen));
    end
    tick();
  endtask

  task automatic test_autorun();
    int t0, t1, t2, t3, t4;
    int busy_seen;
    period = 24'd4;
    run    = 1'b1;
    wait_done("auto_p4_a", t0);
    wait_done("auto_p4_b", t1);
    wait_done("auto_p4_c", t2);
    period = 24'd0;
    wait_done("auto_p0_a", t3);
    wait_done("auto_p0_b", t4);
    run = 1'b0;
    checks++;
    if ((t1 - t0) != 13 || (t2 - t1) != 13) begin
      failures++;
      $display("FAIL auto_period4: got spacing %0d,%0d want 13,13", t1 - t0, t2 - t1);
    end
    checks++;
    if ((t3 - t2) != 10 || (t4 - t3) != 10) begin
      failures++;
      $display("FAIL auto_period0: got spacing %0d,%0d want 10,10", t3 - t2, t4 - t3);
    end
    busy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy === 1'b1) busy_seen++;
    end
    exp_gen += 5;
    checks++;
    if (busy_seen != 0 || gen_count !== 16'(exp_gen)) begin
      failures++;
      $display("FAIL auto_stop: got busy_cycles=%0d gen_count=%0d want 0 %0d", busy_seen, gen_count, 16'(exp_gen));
    end
  endtask

  task automatic test_random();
    logic [63:0] b;
    logic        w;
    for (int i = 0; i < 6; i++) begin
      b = {$urandom, $urandom};
      w = 1'($urandom_range(0, 1));
      load_board(b);
      do_step($sformatf("random%0d", i), w, life(b, w));
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] b;
    logic [63:0] exp;
    logic        w;
    b   = {$urandom, $urandom};
    w   = 1'($urandom_range(0, 1));
    exp = life(b, w);
    load_board(b);
    wrap = w;
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({load_r, r_select} !== {1'b1, 3'd4}) begin
      failures++;
      $display("FAIL rmid_pre: got load_r=%b sel=%0d want 1 4", load_r, r_select);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({load_r, busy, gen_count, user_ready, gen_done} !== 20'd0) begin
      failures++;
      $display("FAIL rmid_reset: got load_r=%b busy=%b cnt=%0d ready=%b done=%b want 0 0 0 0 0",
               load_r, busy, gen_count, user_ready, gen_done);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({user_ready, busy, load_r} !== 3'b100) begin
      failures++;
      $display("FAIL rmid_release: got ready=%b busy=%b load_r=%b want 1 0 0", user_ready, busy, load_r);
    end
    checks++;
    if (cells !== {b[63:40], exp[39:0]}) begin
      failures++;
      $display("FAIL rmid_partial_board: got %h want %h", cells, {b[63:40], exp[39:0]});
    end
    exp_gen = 0;
    b = cells;
    do_step("after_reset", 1'b1, life(b, 1'b1));
  endtask

  initial begin
    reset      = 1'b1;
    clr        = 1'b1;
    user_valid = 1'b0;
    user_row   = '0;
    user_val   = '0;
    step       = 1'b0;
    run        = 1'b0;
    period     = '0;
    wrap       = 1'b0;

    test_reset();
    test_blinker();
    test_corner();
    test_simultaneous();
    test_pending();
    test_stall();
    test_autorun();
    test_random();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
